// File: rtl/vector_pkg.sv
// Shared types and the sprite vertex table for the per-enemy vector point emitter.
package vector_pkg;

  localparam int unsigned VEC_OFFSET_WIDTH = 4;
  localparam int unsigned VEC_NPOINTS      = 5;

  typedef struct packed {
    logic signed [VEC_OFFSET_WIDTH-1:0] dx;
    logic signed [VEC_OFFSET_WIDTH-1:0] dy;
    logic                               beam;
  } vertex_t;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StDone
  } state_e;

  function automatic vertex_t mk_vertex(input int dx, input int dy, input logic beam);
    vertex_t v;
    v.dx   = VEC_OFFSET_WIDTH'(dx);
    v.dy   = VEC_OFFSET_WIDTH'(dy);
    v.beam = beam;
    return v;
  endfunction

  // Square outline; P0 is the blanked move to the start corner.
  localparam vertex_t ENEMY_SPRITE [VEC_NPOINTS] = '{
    mk_vertex(-4, -4, 1'b0),
    mk_vertex( 4, -4, 1'b1),
    mk_vertex( 4,  4, 1'b1),
    mk_vertex(-4,  4, 1'b1),
    mk_vertex(-4, -4, 1'b1)
  };

endpackage

// File: rtl/vec_sat_add.sv
// Unsigned base plus signed offset, clamped to the unsigned output range.
module vec_sat_add #(
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic        [OUT_WIDTH-1:0]    base_i,
  input  logic signed [OFFSET_WIDTH-1:0] offset_i,
  output logic        [OUT_WIDTH-1:0]    sum_o
);

  localparam int unsigned SumW = OUT_WIDTH + 2;

  logic signed [SumW-1:0] base_ext;
  logic signed [SumW-1:0] off_ext;
  logic signed [SumW-1:0] raw;

  always_comb begin
    base_ext = $signed({2'b00, base_i});
    off_ext  = $signed({{(SumW - OFFSET_WIDTH){offset_i[OFFSET_WIDTH-1]}}, offset_i});
    raw      = base_ext + off_ext;
    // Top bit flags underflow, next bit flags overflow past the unsigned range.
    if (raw[SumW-1]) begin
      sum_o = '0;
    end else if (raw[SumW-2]) begin
      sum_o = '1;
    end else begin
      sum_o = raw[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/enemy_vector_emitter.sv
// Per-frame sprite point emitter: snapshots the enemy position and streams clamped
// beam points over a valid/ready handshake.
module enemy_vector_emitter
  import vector_pkg::*;
#(
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned OFFSET_WIDTH = VEC_OFFSET_WIDTH,
  parameter int unsigned NPOINTS      = VEC_NPOINTS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 frame_start,
  input  logic [OUT_WIDTH-1:0] xenemy,
  input  logic [OUT_WIDTH-1:0] yenemy,
  input  logic                 spawn,
  output logic [OUT_WIDTH-1:0] x_out,
  output logic [OUT_WIDTH-1:0] y_out,
  output logic                 beam_on,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned IdxW = $clog2(NPOINTS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NPOINTS - 1);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [OUT_WIDTH-1:0]  xsnap_q, xsnap_d;
  logic [OUT_WIDTH-1:0]  ysnap_q, ysnap_d;
  logic [OUT_WIDTH-1:0]  x_out_q, x_out_d;
  logic [OUT_WIDTH-1:0]  y_out_q, y_out_d;
  logic                  beam_q, beam_d;
  logic                  load;
  vertex_t               vtx;
  logic [OUT_WIDTH-1:0]  x_sat;
  logic [OUT_WIDTH-1:0]  y_sat;

  // The adders see next-cycle snapshot and index so the point lands registered.
  vec_sat_add #(
    .OUT_WIDTH    (OUT_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_sat_x (
    .base_i   (xsnap_d),
    .offset_i (vtx.dx),
    .sum_o    (x_sat)
  );

  vec_sat_add #(
    .OUT_WIDTH    (OUT_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_sat_y (
    .base_i   (ysnap_d),
    .offset_i (vtx.dy),
    .sum_o    (y_sat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xsnap_d = xsnap_q;
    ysnap_d = ysnap_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start && en) begin
          xsnap_d = xenemy;
          ysnap_d = yenemy;
          idx_d   = '0;
          if (spawn) begin
            state_d = StEmit;
            load    = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
            load  = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    vtx     = ENEMY_SPRITE[idx_d];
    x_out_d = load ? x_sat : x_out_q;
    y_out_d = load ? y_sat : y_out_q;
    beam_d  = load ? ((idx_d != '0) && vtx.beam) : beam_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      xsnap_q <= '0;
      ysnap_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      beam_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xsnap_q <= xsnap_d;
      ysnap_q <= ysnap_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      beam_q  <= beam_d;
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign beam_on    = beam_q;
  assign out_valid  = (state_q == StEmit);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_enemy_vector_emitter.sv
// Directed bench for enemy_vector_emitter with hand-computed point sequences.
module tb_enemy_vector_emitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       frame_start;
  logic [7:0] xenemy;
  logic [7:0] yenemy;
  logic       spawn;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic       beam_on;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  enemy_vector_emitter dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .frame_start (frame_start),
    .xenemy      (xenemy),
    .yenemy      (yenemy),
    .spawn       (spawn),
    .x_out       (x_out),
    .y_out       (y_out),
    .beam_on     (beam_on),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pt(input string tag, input int ex, input int ey, input logic eb);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".x"}, {24'd0, x_out}, ex);
    chk({tag, ".y"}, {24'd0, y_out}, ey);
    chk({tag, ".beam"}, {31'd0, beam_on}, {31'd0, eb});
  endtask

  task automatic chk_quiet(input string tag, input logic eb, input logic ed);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, frame_done}, {31'd0, ed});
  endtask

  task automatic start_frame(input int x, input int y, input logic sp);
    xenemy      = 8'(x);
    yenemy      = 8'(y);
    spawn       = sp;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; frame_start = 1'b0;
    xenemy = '0; yenemy = '0; spawn = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_quiet("reset", 1'b0, 1'b0);
    chk("reset.x", {24'd0, x_out}, 32'd0);
    chk("reset.beam", {31'd0, beam_on}, 32'd0);

    // Reset mid-stream, held two cycles
    start_frame(100, 50, 1'b1);
    chk_pt("t1.p0", 96, 46, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk_quiet("t1.rst1", 1'b0, 1'b0);
    chk("t1.rst1.x", {24'd0, x_out}, 32'd0);
    tick();
    chk_quiet("t1.rst2", 1'b0, 1'b0);
    chk("t1.rst2.y", {24'd0, y_out}, 32'd0);
    rst = 1'b0;
    tick();
    chk_quiet("t1.after", 1'b0, 1'b0);

    // Nominal frame
    start_frame(100, 50, 1'b1);
    chk_pt("t2.p0", 96, 46, 1'b0);
    chk("t2.busy", {31'd0, busy}, 32'd1);
    tick(); chk_pt("t2.p1", 104, 46, 1'b1);
    tick(); chk_pt("t2.p2", 104, 54, 1'b1);
    tick(); chk_pt("t2.p3", 96, 54, 1'b1);
    tick(); chk_pt("t2.p4", 96, 46, 1'b1);
    tick(); chk_quiet("t2.done", 1'b1, 1'b1);
    tick(); chk_quiet("t2.idle", 1'b0, 1'b0);

    // Backpressure on P2 for three cycles
    start_frame(100, 50, 1'b1);
    chk_pt("t3.p0", 96, 46, 1'b0);
    tick(); chk_pt("t3.p1", 104, 46, 1'b1);
    tick(); chk_pt("t3.p2a", 104, 54, 1'b1);
    out_ready = 1'b0;
    tick(); chk_pt("t3.p2b", 104, 54, 1'b1);
    tick(); chk_pt("t3.p2c", 104, 54, 1'b1);
    tick(); chk_pt("t3.p2d", 104, 54, 1'b1);
    out_ready = 1'b1;
    tick(); chk_pt("t3.p3", 96, 54, 1'b1);
    tick(); chk_pt("t3.p4", 96, 46, 1'b1);
    tick(); chk_quiet("t3.done", 1'b1, 1'b1);
    tick(); chk_quiet("t3.idle", 1'b0, 1'b0);

    // Saturation at both ends
    start_frame(2, 253, 1'b1);
    chk_pt("t4.p0", 0, 249, 1'b0);
    tick(); chk_pt("t4.p1", 6, 249, 1'b1);
    tick(); chk_pt("t4.p2", 6, 255, 1'b1);
    tick(); chk_pt("t4.p3", 0, 255, 1'b1);
    tick(); chk_pt("t4.p4", 0, 249, 1'b1);
    tick(); chk_quiet("t4.done", 1'b1, 1'b1);
    tick(); chk_quiet("t4.idle", 1'b0, 1'b0);

    // Not spawned: done pulse only
    start_frame(100, 50, 1'b0);
    chk_quiet("t5.done", 1'b1, 1'b1);
    tick(); chk_quiet("t5.idle", 1'b0, 1'b0);
    tick(); chk_quiet("t5.idle2", 1'b0, 1'b0);

    // Disabled: request ignored
    en = 1'b0;
    start_frame(100, 50, 1'b1);
    chk_quiet("t5.en0a", 1'b0, 1'b0);
    tick(); chk_quiet("t5.en0b", 1'b0, 1'b0);
    en = 1'b1;

    // Mid-frame input changes, repeat request and en drop are ignored
    start_frame(100, 50, 1'b1);
    chk_pt("t6.p0", 96, 46, 1'b0);
    tick(); chk_pt("t6.p1", 104, 46, 1'b1);
    xenemy = 8'd200; spawn = 1'b0; frame_start = 1'b1;
    tick(); chk_pt("t6.p2", 104, 54, 1'b1);
    frame_start = 1'b0; en = 1'b0;
    tick(); chk_pt("t6.p3", 96, 54, 1'b1);
    tick(); chk_pt("t6.p4", 96, 46, 1'b1);
    tick(); chk_quiet("t6.done", 1'b1, 1'b1);
    tick(); chk_quiet("t6.idle", 1'b0, 1'b0);
    tick(); chk_quiet("t6.idle2", 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk_quiet("t6.idle3", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
